// File: rtl/opc6_bus_ctrl.sv
// Purpose : bus controller between opc6cpu and the memory/IO fabric (wait states, IO handshake).
// Latency : memory access = ws+2 clocks after the IDLE decode cycle; IO = ack delay + 2, or IO_TIMEOUT + 1 on abort.
// Backpr. : stalls the CPU by holding cpu_clken low until the access completes; internal cycles are free.
//
// Ports
//   clk, reset_b                 clock (rising edge) and asynchronous active-low reset
//   cpu_address/dout/rnw         CPU address, write data and direction (1 = read)
//   cpu_vpa/vda/vio              cycle qualifiers: opcode fetch, memory data, IO data
//   cpu_din, cpu_clken           read data back to the CPU and CPU clock enable
//   mem_addr/wdata/ce/we/rdata   memory port; rdata valid ws cycles after mem_ce rises
//   io_addr/wdata/rnw/req/ack/rdata  IO port with req/ack handshake
//   bus_err                      one-cycle pulse when an IO access times out
module opc6_bus_ctrl #(
  parameter logic [15:0] ROM_BASE   = 16'hF000,
  parameter int unsigned ROM_WS     = 2,
  parameter int unsigned RAM_WS     = 0,
  parameter int unsigned IO_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_b,
  // CPU side
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_dout,
  input  logic        cpu_rnw,
  input  logic        cpu_vpa,
  input  logic        cpu_vda,
  input  logic        cpu_vio,
  output logic [15:0] cpu_din,
  output logic        cpu_clken,
  // memory side
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_ce,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  // IO side
  output logic [7:0]  io_addr,
  output logic [15:0] io_wdata,
  output logic        io_rnw,
  output logic        io_req,
  input  logic        io_ack,
  input  logic [15:0] io_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MWAIT  = 2'd1,
    IOWAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] ROM_WS_C = 4'(ROM_WS);
  localparam logic [3:0] RAM_WS_C = 4'(RAM_WS);
  // Last timeout count still allowed to wait; an unacked request at this count aborts.
  localparam logic [7:0] TMO_LAST = 8'(IO_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [15:0] din_q, din_d;
  logic        mem_ce_q, mem_ce_d;
  logic        mem_we_q, mem_we_d;
  logic        io_req_q, io_req_d;
  logic        bus_err_q, bus_err_d;

  logic        any_cycle;
  logic        mem_cycle;
  logic        in_rom;

  assign any_cycle = cpu_vpa | cpu_vda | cpu_vio;
  // IO qualifier wins when the CPU raises vio together with vpa/vda.
  assign mem_cycle = (cpu_vpa | cpu_vda) & ~cpu_vio;
  assign in_rom    = (cpu_address >= ROM_BASE);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      tmo_cnt_q  <= 8'd0;
      din_q      <= 16'd0;
      mem_ce_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      io_req_q   <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      din_q      <= din_d;
      mem_ce_q   <= mem_ce_d;
      mem_we_q   <= mem_we_d;
      io_req_q   <= io_req_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_vio) begin
          // A still-high ack belongs to the previous handshake; wait for it to close.
          if (!io_ack) state_d = IOWAIT;
        end else if (mem_cycle) begin
          state_d = MWAIT;
        end
      end
      MWAIT: begin
        if (wait_cnt_q == 4'd0) state_d = DONE;
      end
      IOWAIT: begin
        if (io_ack || (tmo_cnt_q == TMO_LAST)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    din_d      = din_q;
    mem_ce_d   = mem_ce_q;
    mem_we_d   = mem_we_q;
    io_req_d   = io_req_q;
    bus_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        mem_ce_d = 1'b0;
        mem_we_d = 1'b0;
        io_req_d = 1'b0;
        if (cpu_vio) begin
          if (!io_ack) begin
            io_req_d  = 1'b1;
            tmo_cnt_d = 8'd0;
          end
        end else if (mem_cycle) begin
          mem_ce_d   = 1'b1;
          mem_we_d   = ~cpu_rnw;
          wait_cnt_d = in_rom ? ROM_WS_C : RAM_WS_C;
        end
      end

      MWAIT: begin
        if (wait_cnt_q == 4'd0) begin
          mem_ce_d = 1'b0;
          if (cpu_rnw) din_d = mem_rdata;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      IOWAIT: begin
        if (io_ack) begin
          // Ack beats a coincident timeout: the transfer really happened.
          io_req_d = 1'b0;
          if (cpu_rnw) din_d = io_rdata;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
          if (tmo_cnt_q == TMO_LAST) begin
            io_req_d  = 1'b0;
            bus_err_d = 1'b1;
            if (cpu_rnw) din_d = 16'hFFFF;
          end
        end
      end

      DONE: begin
        // mem_we stays up through DONE and drops with the return to IDLE.
        mem_ce_d = 1'b0;
        mem_we_d = 1'b0;
        io_req_d = 1'b0;
      end

      default: begin
        mem_ce_d = 1'b0;
        mem_we_d = 1'b0;
        io_req_d = 1'b0;
      end
    endcase
  end

  // cpu_clken is held high during reset so the CPU's clken-gated reset logic keeps running.
  assign cpu_clken = ~reset_b
                   | (state_q == DONE)
                   | ((state_q == IDLE) & ~any_cycle);

  assign cpu_din   = din_q;
  assign mem_addr  = cpu_address;
  assign mem_wdata = cpu_dout;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign io_addr   = cpu_address[7:0];
  assign io_wdata  = cpu_dout;
  assign io_rnw    = cpu_rnw;
  assign io_req    = io_req_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_opc6_bus_ctrl.sv
// Purpose : self-checking bench for opc6_bus_ctrl, acting as CPU, memory and IO peripheral.
// Latency : expected cycle counts derived from wait-state / handshake / timeout rules.
// Backpr. : waits on cpu_clken with a bounded cycle budget per access.
module tb_opc6_bus_ctrl;

  localparam logic [15:0] ROM_BASE = 16'hF000;
  localparam int ROM_WS = 2;
  localparam int RAM_WS = 0;
  localparam int T      = 64;

  localparam int K_NONE = 0;
  localparam int K_MEM  = 1;
  localparam int K_IO   = 2;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [15:0] cpu_address, cpu_dout;
  logic        cpu_rnw, cpu_vpa, cpu_vda, cpu_vio;
  logic [15:0] cpu_din;
  logic        cpu_clken;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ce, mem_we;
  logic [7:0]  io_addr;
  logic [15:0] io_wdata, io_rdata;
  logic        io_rnw, io_req, io_ack, bus_err;

  int          errors = 0;
  int          checks = 0;
  int          hold   = 0;      // cycles the peripheral keeps io_ack after io_req drops
  logic [15:0] exp_din;

  always #5 clk = ~clk;

  opc6_bus_ctrl #(
    .ROM_BASE  (ROM_BASE),
    .ROM_WS    (ROM_WS),
    .RAM_WS    (RAM_WS),
    .IO_TIMEOUT(T)
  ) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .cpu_address(cpu_address),
    .cpu_dout   (cpu_dout),
    .cpu_rnw    (cpu_rnw),
    .cpu_vpa    (cpu_vpa),
    .cpu_vda    (cpu_vda),
    .cpu_vio    (cpu_vio),
    .cpu_din    (cpu_din),
    .cpu_clken  (cpu_clken),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rnw     (io_rnw),
    .io_req     (io_req),
    .io_ack     (io_ack),
    .io_rdata   (io_rdata),
    .bus_err    (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU access. Called just after a falling edge; returns on the falling edge that
  // follows the clken-high cycle. d = io_ack delay in io_req cycles (>= T means never),
  // h = extra cycles io_ack lingers after io_req drops, alt = vpa instead of vda for
  // memory, or vda raised alongside vio for IO.
  task automatic run_txn(input string tag, input int kind, input logic [15:0] addr,
                         input logic rnw, input logic [15:0] data,
                         input int d, input int h, input bit alt);
    int ws, blk, e_clk, e_ce, e_we, e_req, e_err;
    int clk_at, n_ce, n_we, n_req, n_err, ce_seen, req_seen;
    bit bus_ok;

    ws    = (addr >= ROM_BASE) ? ROM_WS : RAM_WS;
    blk   = (kind == K_IO && io_ack) ? hold : 0;
    e_clk = 0; e_ce = 0; e_we = 0; e_req = 0; e_err = 0;
    if (kind == K_MEM) begin
      e_clk = ws + 2;
      e_ce  = ws + 1;
      e_we  = rnw ? 0 : ws + 2;
      if (rnw) exp_din = data;
    end else if (kind == K_IO) begin
      if (d <= T - 1) begin
        e_req = d + 1;
        e_clk = blk + d + 2;
        if (rnw) exp_din = data;
      end else begin
        e_req = T;
        e_clk = blk + T + 1;
        e_err = 1;
        if (rnw) exp_din = 16'hFFFF;
      end
    end

    cpu_address = addr;
    cpu_rnw     = rnw;
    cpu_dout    = rnw ? ~data : data;
    cpu_vpa     = (kind == K_MEM) && alt;
    cpu_vda     = ((kind == K_MEM) && !alt) || ((kind == K_IO) && alt);
    cpu_vio     = (kind == K_IO);

    clk_at = -1; n_ce = 0; n_we = 0; n_req = 0; n_err = 0;
    ce_seen = 0; req_seen = 0; bus_ok = 1'b1;
    for (int c = 0; c < 400 && clk_at < 0; c++) begin
      #1;
      if (mem_ce === 1'b1) begin
        n_ce++;
        bus_ok &= (mem_addr === addr) && (rnw || mem_wdata === data);
      end
      if (mem_we === 1'b1) n_we++;
      if (io_req === 1'b1) begin
        n_req++;
        bus_ok &= (io_addr === addr[7:0]) && (io_rnw === rnw) && (rnw || io_wdata === data);
      end
      if (bus_err === 1'b1) n_err++;
      if (cpu_clken === 1'b1) clk_at = c;
      // memory: data valid only ws cycles after mem_ce rose
      if (mem_ce === 1'b1) begin
        mem_rdata = (ce_seen == ws) ? data : ~data;
        ce_seen++;
      end else begin
        ce_seen   = 0;
        mem_rdata = ~data;
      end
      // IO peripheral
      if (io_req === 1'b1) begin
        if (req_seen >= d) begin
          io_ack = 1'b1;
          hold   = h;
        end
        req_seen++;
      end else if (io_ack) begin
        if (hold == 0) io_ack = 1'b0;
        else           hold--;
      end
      io_rdata = io_ack ? data : ~data;
      @(negedge clk);
    end

    chk({tag, " clken_cycle"}, 32'(clk_at), 32'(e_clk));
    chk({tag, " mem_ce_cycles"}, 32'(n_ce), 32'(e_ce));
    chk({tag, " mem_we_cycles"}, 32'(n_we), 32'(e_we));
    chk({tag, " io_req_cycles"}, 32'(n_req), 32'(e_req));
    chk({tag, " bus_err_cycles"}, 32'(n_err), 32'(e_err));
    chk({tag, " bus_stable"}, 32'(bus_ok), 32'd1);
    chk({tag, " cpu_din"}, 32'(cpu_din), 32'(exp_din));
  endtask

  initial begin
    int          r, kind, d, h;
    logic [15:0] addr, data;
    logic        rnw;
    bit          alt;

    reset_b     = 1'b0;
    cpu_address = 16'h0100;
    cpu_dout    = 16'h0000;
    cpu_rnw     = 1'b1;
    cpu_vpa     = 1'b1;
    cpu_vda     = 1'b0;
    cpu_vio     = 1'b0;
    mem_rdata   = 16'h0000;
    io_ack      = 1'b0;
    io_rdata    = 16'h0000;
    exp_din     = 16'h0000;

    repeat (3) @(negedge clk);
    #1;
    chk("reset clken", 32'(cpu_clken), 32'd1);
    chk("reset mem_ce", 32'(mem_ce), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset io_req", 32'(io_req), 32'd0);
    chk("reset bus_err", 32'(bus_err), 32'd0);
    chk("reset cpu_din", 32'(cpu_din), 32'd0);
    @(negedge clk);
    reset_b = 1'b1;

    // first fetch after reset, RAM read with zero wait states
    run_txn("ram_fetch", K_MEM, 16'h0100, 1'b1, 16'h1234, 0, 0, 1'b1);
    run_txn("rom_fetch", K_MEM, 16'hF800, 1'b1, 16'h5A5A, 0, 0, 1'b1);
    run_txn("ram_write", K_MEM, 16'h0200, 1'b0, 16'hBEEF, 0, 0, 1'b0);
    run_txn("ram_edge",  K_MEM, 16'hEFFF, 1'b1, 16'h0EFF, 0, 0, 1'b0);
    run_txn("rom_edge",  K_MEM, 16'hF000, 1'b1, 16'hF00D, 0, 0, 1'b0);
    run_txn("internal",  K_NONE, 16'h1111, 1'b1, 16'h0000, 0, 0, 1'b0);
    // IO read, ack after 5 cycles, ack lingers so the next IO access is held off
    run_txn("io_read",   K_IO, 16'hFF10, 1'b1, 16'h00A5, 5, 3, 1'b0);
    run_txn("io_blocked", K_IO, 16'h0011, 1'b1, 16'h7777, 2, 0, 1'b0);
    run_txn("io_timeout_rd", K_IO, 16'h0010, 1'b1, 16'h0000, 1000, 0, 1'b0);
    run_txn("io_timeout_wr", K_IO, 16'h0020, 1'b0, 16'hCAFE, 1000, 0, 1'b0);
    run_txn("io_ack_at_limit", K_IO, 16'h0030, 1'b1, 16'h3C3C, T - 1, 0, 1'b0);
    run_txn("io_over_vda", K_IO, 16'h0040, 1'b0, 16'h4242, 0, 1, 1'b1);
    run_txn("io_write_blk", K_IO, 16'h0041, 1'b0, 16'h4343, 1, 2, 1'b0);

    // reset in the middle of a ROM fetch aborts it at once
    io_ack      = 1'b0;
    hold        = 0;
    cpu_address = 16'hF800;
    cpu_rnw     = 1'b1;
    cpu_vpa     = 1'b1;
    cpu_vda     = 1'b0;
    cpu_vio     = 1'b0;
    @(negedge clk);
    #1;
    chk("arst pre mem_ce", 32'(mem_ce), 32'd1);
    #2;
    reset_b = 1'b0;
    #1;
    chk("arst mem_ce", 32'(mem_ce), 32'd0);
    chk("arst io_req", 32'(io_req), 32'd0);
    chk("arst clken", 32'(cpu_clken), 32'd1);
    chk("arst cpu_din", 32'(cpu_din), 32'd0);
    exp_din = 16'h0000;
    @(negedge clk);
    reset_b = 1'b1;

    // randomized accesses
    for (int i = 0; i < 70; i++) begin
      r    = $urandom_range(0, 9);
      kind = (r < 1) ? K_NONE : (r < 6) ? K_MEM : K_IO;
      addr = 16'($urandom);
      if ($urandom_range(0, 2) == 0) addr[15:12] = 4'hF;
      data = 16'($urandom);
      rnw  = 1'($urandom_range(0, 1));
      alt  = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 9);
      d    = (r < 7) ? $urandom_range(0, 6) : (r == 7) ? T - 1 : (r == 8) ? T - 2 : 300;
      h    = $urandom_range(0, 3);
      run_txn("rnd", kind, addr, rnw, data, d, h, alt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
